// File: rtl/geom_compute_aabb_seq.sv
// Sequential sphere/box AABB builder: six centre +/- extent sums through one
// handshaked single-precision adder, plus that adder.

module geom_fp_add (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {GET_A, GET_B, ADD, NORM, ROUND, PUT_Z} add_state_t;

  add_state_t  st;
  logic [31:0] a, b, hi, lo;
  logic [27:0] m, sum;
  logic [9:0]  e, re;
  logic        sgn, nan, inf;
  logic [7:0]  eh, el, d;
  logic [26:0] mh, ml, mls;
  logic [24:0] rm;

  // Order operands by magnitude so the difference of mantissas is never negative.
  always_comb begin
    hi  = (b[30:0] > a[30:0]) ? b : a;
    lo  = (b[30:0] > a[30:0]) ? a : b;
    eh  = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
    el  = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
    mh  = {|hi[30:23], hi[22:0], 3'b000};
    ml  = {|lo[30:23], lo[22:0], 3'b000};
    d   = eh - el;
    if (d >= 8'd27) mls = {26'd0, |ml};
    else            mls = (ml >> d) | {26'd0, |(ml & ((27'd1 << d) - 27'd1))};
    sum = (hi[31] == lo[31]) ? {1'b0, mh} + {1'b0, mls} : {1'b0, mh} - {1'b0, mls};
    inf = (hi[30:23] == 8'hFF);
    nan = inf && ((hi[22:0] != 23'd0) || (lo[30:23] == 8'hFF && hi[31] != lo[31]));
  end

  // Round to nearest even; bit 2 is guard, bits 1:0 round/sticky.
  always_comb begin
    rm = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
    re = e;
    if (rm[24]) begin
      rm = rm >> 1;
      re = e + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      b            <= '0;
      m            <= '0;
      e            <= '0;
      sgn          <= 1'b0;
    end else begin
      case (st)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b1;
            st          <= GET_B;
          end
        end
        GET_B: if (input_b_ack && input_b_stb) begin
          b           <= input_b;
          input_b_ack <= 1'b0;
          st          <= ADD;
        end
        ADD: begin
          if (inf) begin
            output_z     <= nan ? 32'h7FC00000 : hi;
            output_z_stb <= 1'b1;
            st           <= PUT_Z;
          end else if (sum == 28'd0) begin
            output_z     <= {hi[31] & lo[31], 31'd0};
            output_z_stb <= 1'b1;
            st           <= PUT_Z;
          end else begin
            m   <= sum;
            e   <= {2'b00, eh};
            sgn <= hi[31];
            st  <= NORM;
          end
        end
        NORM: begin
          if (m[27]) begin
            m  <= {1'b0, m[27:2], m[1] | m[0]};
            e  <= e + 10'd1;
            st <= ROUND;
          end else if (!m[26] && e > 10'd1) begin
            m <= m << 1;
            e <= e - 10'd1;
          end else begin
            st <= ROUND;
          end
        end
        ROUND: begin
          output_z     <= (re >= 10'd255) ? {sgn, 8'hFF, 23'd0}
                                          : {sgn, rm[23] ? re[7:0] : 8'd0, rm[22:0]};
          output_z_stb <= 1'b1;
          st           <= PUT_Z;
        end
        PUT_Z: if (output_z_stb && output_z_ack) begin
          output_z_stb <= 1'b0;
          st           <= GET_A;
        end
        default: st <= GET_A;
      endcase
    end
  end
endmodule

module geom_compute_aabb_seq #(
  parameter int TIMEOUT   = 255,
  parameter int DONE_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [31:0] ext0,
  input  logic [31:0] ext1,
  input  logic [31:0] ext2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] aabb0,
  output logic [31:0] aabb1,
  output logic [31:0] aabb2,
  output logic [31:0] aabb3,
  output logic [31:0] aabb4,
  output logic [31:0] aabb5
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state;
  logic [2:0]      idx;
  logic [TW-1:0]   tcnt;
  logic [31:0]     cx, cy, cz, ex, ey, ez;
  logic [5:0][31:0] res;
  logic            a_stb, b_stb, got_a, got_b, z_ack, arst;
  logic            a_ack, b_ack, z_stb, a_hs, b_hs, both, abort, add_rst;
  logic [31:0]     sum_z, opa, opb, ext_sel;

  assign a_hs    = a_stb & a_ack;
  assign b_hs    = b_stb & b_ack;
  assign both    = (got_a | a_hs) & (got_b | b_hs);
  assign abort   = (tcnt == TW'(TIMEOUT)) &&
                   ((state == ISSUE && !both) || (state == WAIT && !z_stb));
  assign add_rst = rst | arst;

  // Even ops subtract: the (already absolute) extent goes in with its sign flipped.
  always_comb begin
    opa     = cx;
    ext_sel = ex;
    case (idx[2:1])
      2'd1:    begin opa = cy; ext_sel = ey; end
      2'd2:    begin opa = cz; ext_sel = ez; end
      default: ;
    endcase
    opb = {ext_sel[31] ^ ~idx[0], ext_sel[30:0]};
  end

  geom_fp_add u_add (
    .clk          (clk),
    .rst          (add_rst),
    .input_a      (opa),
    .input_a_stb  (a_stb),
    .input_a_ack  (a_ack),
    .input_b      (opb),
    .input_b_stb  (b_stb),
    .input_b_ack  (b_ack),
    .output_z     (sum_z),
    .output_z_stb (z_stb),
    .output_z_ack (z_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      tcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      arst  <= 1'b0;
      a_stb <= 1'b0;
      b_stb <= 1'b0;
      got_a <= 1'b0;
      got_b <= 1'b0;
      z_ack <= 1'b0;
      res   <= '0;
      cx    <= '0;
      cy    <= '0;
      cz    <= '0;
      ex    <= '0;
      ey    <= '0;
      ez    <= '0;
    end else begin
      err  <= 1'b0;
      arst <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cx    <= x;
          cy    <= y;
          cz    <= z;
          ex    <= {1'b0, ext0[30:0]};
          ey    <= {1'b0, mode ? ext1[30:0] : ext0[30:0]};
          ez    <= {1'b0, mode ? ext2[30:0] : ext0[30:0]};
          idx   <= '0;
          tcnt  <= '0;
          a_stb <= 1'b1;
          b_stb <= 1'b1;
          got_a <= 1'b0;
          got_b <= 1'b0;
          busy  <= 1'b1;
          done  <= 1'b0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (a_hs) begin a_stb <= 1'b0; got_a <= 1'b1; end
          if (b_hs) begin b_stb <= 1'b0; got_b <= 1'b1; end
          if (both) begin
            tcnt  <= '0;
            state <= WAIT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT: begin
          if (z_stb) begin
            res[idx] <= sum_z;
            z_ack    <= 1'b1;
            state    <= NEXT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        NEXT: begin
          z_ack <= 1'b0;
          if (idx == 3'd5) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            tcnt  <= '0;
            a_stb <= 1'b1;
            b_stb <= 1'b1;
            got_a <= 1'b0;
            got_b <= 1'b0;
            state <= ISSUE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (DONE_HOLD == 0) done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Abandon the job; the adder is flushed for one cycle, results keep partial state.
      if (abort) begin
        err   <= 1'b1;
        arst  <= 1'b1;
        busy  <= 1'b0;
        a_stb <= 1'b0;
        b_stb <= 1'b0;
        tcnt  <= '0;
        state <= IDLE;
      end
    end
  end

  assign aabb0 = res[0];
  assign aabb1 = res[1];
  assign aabb2 = res[2];
  assign aabb3 = res[3];
  assign aabb4 = res[4];
  assign aabb5 = res[5];
endmodule

// File: tb/tb_geom_compute_aabb_seq.sv
// Randomized bench for geom_compute_aabb_seq against a real-arithmetic AABB model;
// three instances cover default, done-hold and short-timeout configurations.

module tb_geom_compute_aabb_seq;
  typedef logic [5:0][31:0] vec6_t;

  logic        clk = 1'b0, rst = 1'b1, mode = 1'b0;
  logic        start = 1'b0, start_h = 1'b0, start_t = 1'b0;
  logic [31:0] x = '0, y = '0, z = '0, ext0 = '0, ext1 = '0, ext2 = '0;
  logic        busy_d, done_d, err_d, busy_h, done_h, err_h, busy_t, done_t, err_t;
  vec6_t       res_d, res_h, res_to;
  int          n_chk = 0, n_fail = 0, done_cnt_d = 0, done_cnt_t = 0;

  always #5 clk = ~clk;

  geom_compute_aabb_seq u_d (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y), .z(z),
    .ext0(ext0), .ext1(ext1), .ext2(ext2), .busy(busy_d), .done(done_d), .err(err_d),
    .aabb0(res_d[0]), .aabb1(res_d[1]), .aabb2(res_d[2]),
    .aabb3(res_d[3]), .aabb4(res_d[4]), .aabb5(res_d[5]));

  geom_compute_aabb_seq #(.DONE_HOLD(1)) u_h (
    .clk(clk), .rst(rst), .start(start_h), .mode(mode), .x(x), .y(y), .z(z),
    .ext0(ext0), .ext1(ext1), .ext2(ext2), .busy(busy_h), .done(done_h), .err(err_h),
    .aabb0(res_h[0]), .aabb1(res_h[1]), .aabb2(res_h[2]),
    .aabb3(res_h[3]), .aabb4(res_h[4]), .aabb5(res_h[5]));

  geom_compute_aabb_seq #(.TIMEOUT(2)) u_t (
    .clk(clk), .rst(rst), .start(start_t), .mode(mode), .x(x), .y(y), .z(z),
    .ext0(ext0), .ext1(ext1), .ext2(ext2), .busy(busy_t), .done(done_t), .err(err_t),
    .aabb0(res_to[0]), .aabb1(res_to[1]), .aabb2(res_to[2]),
    .aabb3(res_to[3]), .aabb4(res_to[4]), .aabb5(res_to[5]));

  always @(posedge clk) begin
    if (done_d) done_cnt_d++;
    if (done_t) done_cnt_t++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Real values used here are exact in single precision, as are their sums.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic real rabs(input real r);
    return (r < 0.0) ? -r : r;
  endfunction

  function automatic real rv();
    int k = $urandom_range(0, 4);
    int m = $urandom_range(0, 65535);
    return real'(m - 32768) / real'(1 << k);
  endfunction

  function automatic vec6_t model(input logic md, input real cx, cy, cz, e0, e1, e2);
    real ex = rabs(e0);
    real ey = md ? rabs(e1) : ex;
    real ez = md ? rabs(e2) : ex;
    vec6_t r;
    r[0] = r2f(cx - ex); r[1] = r2f(cx + ex);
    r[2] = r2f(cy - ey); r[3] = r2f(cy + ey);
    r[4] = r2f(cz - ez); r[5] = r2f(cz + ez);
    return r;
  endfunction

  task automatic load(input logic md, input logic [31:0] ix, iy, iz, e0, e1, e2);
    mode = md; x = ix; y = iy; z = iz; ext0 = e0; ext1 = e1; ext2 = e2;
  endtask

  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!(which == 0 ? done_d : which == 1 ? done_h : err_t) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, which == 0 ? done_d : which == 1 ? done_h : err_t, 1);
  endtask

  task automatic chk_res(input string tag, input vec6_t got, input vec6_t exp);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_aabb%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic job_d(input string tag, input vec6_t exp);
    int c0 = done_cnt_d;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy"}, busy_d, 1);
    wait_sig(0, tag);
    chk_res(tag, res_d, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, done_d, 0);
    chk({tag, "_idle"}, busy_d, 0);
    chk({tag, "_ndone"}, done_cnt_d - c0, 1);
  endtask

  task automatic rand_load(output vec6_t exp);
    real c0 = rv(), c1 = rv(), c2 = rv(), e0 = rv(), e1 = rv(), e2 = rv();
    logic md = 1'($urandom_range(0, 1));
    load(md, r2f(c0), r2f(c1), r2f(c2), r2f(e0), r2f(e1), r2f(e2));
    exp = model(md, c0, c1, c2, e0, e1, e2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec6_t exp, exp2;
    int held, c0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_d, 0);
    chk("rst_done", done_d, 0);
    chk("rst_err", err_d, 0);
    chk("rst_aabb0", res_d[0], 0);
    chk("rst_hold_aabb5", res_h[5], 0);

    load(1'b0, 32'h3F800000, 32'h0, 32'hC0000000, 32'h3F000000, 32'h12345678, 32'h9ABCDEF0);
    job_d("sphere", {32'hBFC00000, 32'hC0200000, 32'h3F000000, 32'hBF000000, 32'h3FC00000, 32'h3F000000});

    load(1'b1, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'hC0000000, 32'h40800000);
    job_d("box", {32'h40800000, 32'hC0800000, 32'h40000000, 32'hC0000000, 32'h3F800000, 32'hBF800000});

    for (int j = 0; j < 12; j++) begin
      rand_load(exp);
      job_d($sformatf("rand%0d", j), exp);
    end

    // Restart and input changes while busy must not disturb the running job.
    rand_load(exp);
    c0 = done_cnt_d;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rand_load(exp2);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_sig(0, "restart");
    chk_res("restart", res_d, exp);
    repeat (3) @(negedge clk);
    chk("restart_ndone", done_cnt_d - c0, 1);
    chk("restart_idle", busy_d, 0);

    // Reset during the aabb3 wait, with start held high alongside reset.
    load(1'b0, 32'h3F800000, 32'h0, 32'hC0000000, 32'h3F000000, 32'h0, 32'h0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    held = 0;
    while (res_d[2] !== 32'hBF000000 && held < 2000) begin @(negedge clk); held++; end
    chk("midrst_aabb2", res_d[2], 32'hBF000000);
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy_d, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy_d, 0);
    chk("midrst_done", done_d, 0);
    chk("midrst_err", err_d, 0);
    chk_res("midrst", res_d, '0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_start_ignored", busy_d, 0);
    rand_load(exp);
    job_d("after_rst", exp);

    // Short timeout instance gives up while the adder is still computing.
    load(1'b0, 32'h3F800000, 32'h0, 32'hC0000000, 32'h3F000000, 32'h0, 32'h0);
    @(negedge clk); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0;
    chk("to_busy", busy_t, 1);
    wait_sig(2, "to");
    chk("to_busy_off", busy_t, 0);
    chk("to_done", done_t, 0);
    chk("to_aabb0", res_to[0], 0);
    @(negedge clk);
    chk("to_err_pulse", err_t, 0);
    repeat (3) @(negedge clk);
    chk("to_ndone", done_cnt_t, 0);
    chk("to_idle", busy_t, 0);

    // Done-hold instance keeps done until the next accepted start.
    rand_load(exp);
    @(negedge clk); start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    wait_sig(1, "hold");
    chk_res("hold", res_h, exp);
    held = 0;
    repeat (20) begin @(negedge clk); if (done_h) held++; end
    chk("hold_cycles", held, 20);
    rand_load(exp);
    start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    chk("hold_clear", done_h, 0);
    chk("hold_busy", busy_h, 1);
    wait_sig(1, "hold2");
    chk_res("hold2", res_h, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
